// File: rtl/bcd_seg_scan.sv
// Filters the CPU's 3-digit BCD output, commits it only on frame boundaries and scans an active-low 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module bcd_seg_scan #(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_CYCLES  = 200,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [11:0] disp_val,
  output logic        commit
);

  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2
  } digit_e;

  logic [CNT_W-1:0]  r_cnt;
  digit_e            r_idx;
  digit_e            w_idxNext;
  logic [11:0]       r_cand;
  logic [STAB_W-1:0] r_stabCnt;
  logic              r_stable;
  logic [11:0]       r_dispVal;
  logic              r_commit;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;

  logic              w_tick;
  logic              w_boundary;
  logic              w_commitNow;
  logic [3:0]        w_nibble;
  logic [3:0]        w_anDrive;
  logic              w_blankDigit;
  logic [6:0]        w_segDigit;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h06;
    endcase
    return pat;
  endfunction

  assign w_tick      = (r_cnt == CNT_MAX);
  assign w_boundary  = w_tick && (r_idx == DIG2);
  assign w_commitNow = w_boundary && r_stable && (r_cand != r_dispVal);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= DIG0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      r_idx <= w_idxNext;
    end
  end

  always_comb begin
    w_idxNext = r_idx;
    if (w_tick) begin
      case (r_idx)
        DIG0:    w_idxNext = DIG1;
        DIG1:    w_idxNext = DIG2;
        default: w_idxNext = DIG0;
      endcase
    end
  end

  // A changing input restarts the count; the count saturates once the value has been seen long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand    <= '0;
      r_stabCnt <= '0;
      r_stable  <= 1'b0;
    end else if (bcd_in != r_cand) begin
      r_cand    <= bcd_in;
      r_stabCnt <= '0;
      r_stable  <= 1'b0;
    end else if (r_stabCnt == STAB_MAX) begin
      r_stable  <= 1'b1;
    end else begin
      r_stabCnt <= r_stabCnt + STAB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dispVal <= '0;
      r_commit  <= 1'b0;
    end else begin
      r_commit <= w_commitNow;
      if (w_commitNow) begin
        r_dispVal <= r_cand;
      end
    end
  end

  always_comb begin
    w_nibble     = 4'h0;
    w_anDrive    = 4'b1111;
    w_blankDigit = 1'b0;
    case (r_idx)
      DIG0: begin
        w_nibble  = r_dispVal[3:0];
        w_anDrive = 4'b1110;
      end
      DIG1: begin
        w_nibble  = r_dispVal[7:4];
        w_anDrive = 4'b1101;
`ifdef SEG_LZB_EN
        w_blankDigit = (r_dispVal[11:8] == 4'h0) && (r_dispVal[7:4] == 4'h0);
`endif
      end
      DIG2: begin
        w_nibble  = r_dispVal[11:8];
        w_anDrive = 4'b1011;
`ifdef SEG_LZB_EN
        w_blankDigit = (r_dispVal[11:8] == 4'h0);
`endif
      end
      default: begin
        w_nibble  = 4'h0;
        w_anDrive = 4'b1111;
      end
    endcase
    w_segDigit = w_blankDigit ? 7'h7F : decode(w_nibble);
  end

  // Dead time at the start of every slot keeps the previous digit from ghosting onto the next anode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
    end else if (r_cnt < BLANK_END) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= w_anDrive;
      r_seg <= w_segDigit;
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign dp       = 1'b1;
  assign disp_val = r_dispVal;
  assign commit   = r_commit;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan: vector table of display values, scoreboard of expected commits,
// plus hand sequences for input churn and mid-slot reset. Expectations follow SEG_LZB_EN when defined.
module tb_bcd_seg_scan;

  localparam int REFRESH_DIV   = 4;
  localparam int BLANK_CYCLES  = 1;
  localparam int STABLE_CYCLES = 3;

  logic        clk;
  logic        reset;
  logic [11:0] bcd_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [11:0] disp_val;
  logic        commit;

  int checks;
  int failures;

  logic [11:0] sbQ[$];
  logic [3:0]  prevAn;

  typedef struct {
    logic [11:0] bcd;
    logic [6:0]  seg0;
    logic [6:0]  seg1;
    logic [6:0]  seg2;
    logic [6:0]  lzb1;
    logic [6:0]  lzb2;
  } vec_t;

  vec_t vecs[8];

  bcd_seg_scan #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bcd_in  (bcd_in),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .disp_val(disp_val),
    .commit  (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timed out", name);
  endtask

  function automatic logic legalAn(input logic [3:0] a);
    return (a == 4'b1111) || (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011);
  endfunction

  // Continuous checks: anode legality, dp, no slot-to-slot change without blanking, commit scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prevAn = 4'b1111;
    end else begin
      checkOutput("an_legal", 12'(legalAn(an)), 12'd1);
      checkOutput("dp_off", 12'(dp), 12'd1);
      if (an != 4'b1111 && prevAn != 4'b1111) begin
        checkOutput("blank_between_slots", 12'(an), 12'(prevAn));
      end
      if (commit) begin
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_commit actual=%h expected=none", disp_val);
        end else begin
          checkOutput("commit_value", disp_val, sbQ.pop_front());
        end
      end
      prevAn = an;
    end
  end

  task automatic applyStimulus(input logic [11:0] value, input bit expectCommit);
    bcd_in = value;
    if (expectCommit) sbQ.push_back(value);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      failNow(name);
      sbQ.delete();
    end
  endtask

  task automatic waitAnode(input logic [3:0] pat, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (an == pat) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic checkSlot(input string name, input logic [3:0] pat, input logic [6:0] expSeg);
    bit ok;
    waitAnode(pat, ok);
    if (!ok) failNow(name);
    else     checkOutput(name, 12'(seg), 12'(expSeg));
  endtask

  initial begin
    logic [6:0] e1;
    logic [6:0] e2;
    bit         ok;

    checks   = 0;
    failures = 0;
    prevAn   = 4'b1111;

    vecs[0] = '{12'h123, 7'h30, 7'h24, 7'h79, 7'h24, 7'h79};
    vecs[1] = '{12'h0A5, 7'h12, 7'h06, 7'h40, 7'h06, 7'h7F};
    vecs[2] = '{12'h007, 7'h78, 7'h40, 7'h40, 7'h7F, 7'h7F};
    vecs[3] = '{12'h999, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};
    vecs[4] = '{12'h680, 7'h40, 7'h00, 7'h02, 7'h00, 7'h02};
    vecs[5] = '{12'h0F0, 7'h40, 7'h06, 7'h40, 7'h06, 7'h7F};
    vecs[6] = '{12'h000, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F};
    vecs[7] = '{12'h100, 7'h40, 7'h40, 7'h79, 7'h40, 7'h79};

    // Reset held for two cycles, then the first driven slot shows ones digit '0'.
    reset  = 1'b1;
    bcd_in = 12'h000;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_an", 12'(an), 12'h00F);
    checkOutput("reset_seg", 12'(seg), 12'h07F);
    checkOutput("reset_disp", disp_val, 12'h000);
    checkOutput("reset_commit", 12'(commit), 12'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("first_blank_an", 12'(an), 12'h00F);
    @(negedge clk);
    checkOutput("first_drive_an", 12'(an), 12'h00E);
    checkOutput("first_drive_seg", 12'(seg), 12'h040);

    for (int i = 0; i < 8; i++) begin
`ifdef SEG_LZB_EN
      e1 = vecs[i].lzb1;
      e2 = vecs[i].lzb2;
`else
      e1 = vecs[i].seg1;
      e2 = vecs[i].seg2;
`endif
      applyStimulus(vecs[i].bcd, 1'b1);
      waitDrain("commit_wait");
      checkOutput("disp_val", disp_val, vecs[i].bcd);
      checkSlot("seg_ones", 4'b1110, vecs[i].seg0);
      checkSlot("seg_tens", 4'b1101, e1);
      checkSlot("seg_hundreds", 4'b1011, e2);
    end

    // Input toggling every two cycles never becomes stable, so nothing commits.
    for (int n = 0; n < 30; n++) begin
      applyStimulus((n % 2 == 0) ? 12'h123 : 12'h456, 1'b0);
      @(negedge clk);
      @(negedge clk);
    end
    applyStimulus(12'h100, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("toggle_disp_held", disp_val, 12'h100);

    // Reset during the tens slot while a new stable value is pending.
    waitAnode(4'b1110, ok);
    if (!ok) failNow("sync_dig0");
    applyStimulus(12'h321, 1'b0);
    waitAnode(4'b1101, ok);
    if (!ok) failNow("sync_dig1");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_an", 12'(an), 12'h00F);
    checkOutput("midreset_seg", 12'(seg), 12'h07F);
    checkOutput("midreset_disp", disp_val, 12'h000);
    checkOutput("midreset_commit", 12'(commit), 12'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(12'h321, 1'b1);
    @(negedge clk);
    checkOutput("postreset_blank_an", 12'(an), 12'h00F);
    @(negedge clk);
    checkOutput("postreset_drive_an", 12'(an), 12'h00E);
    checkOutput("postreset_drive_seg", 12'(seg), 12'h040);
    waitDrain("postreset_commit_wait");
    checkOutput("postreset_disp", disp_val, 12'h321);
    checkSlot("postreset_ones", 4'b1110, 7'h79);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
